ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single instruction/data RAM interface of the execution unit between two requesters: the fetch stage (IF, read-only) and the load/store path (LS, read/write).
- Issues at most one RAM command per cycle, with registered command outputs.
- Tags every in-flight read so each response returns to the correct requester.
- Supports a fetch flush that discards in-flight instruction reads after a PC redirect.

Parameters:
- RD_LATENCY, 1: cycles from a registered ram_rd_en to valid ram_rd_data. Legal range 1..4.
- STARVE_LIMIT, 4: consecutive blocked fetch cycles before fetch is forced to win. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch read request
- if_req_addr  in  32  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_flush  in  1  discard all in-flight fetch reads
- if_rsp_valid  out  1  fetch read data valid
- if_rsp_data  out  32  fetch read data
- ls_req_valid  in  1  load/store request
- ls_req_we  in  1  1 = write, 0 = read
- ls_req_addr  in  32  load/store address
- ls_req_wdata  in  32  store data
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_rsp_valid  out  1  load data valid (reads only)
- ls_rsp_data  out  32  load data
- ram_rd_en  out  1  RAM read strobe, registered
- ram_rd_addr  out  32  RAM read address, registered
- ram_rd_data  in  32  RAM read data
- ram_wr_en  out  1  RAM write strobe, registered
- ram_wr_addr  out  32  RAM write address, registered
- ram_wr_data  out  32  RAM write data, registered

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0.
  - Tag pipeline cleared, so in-flight responses are never delivered.
  - Starvation counter 0.
- Handshake: a request is accepted on a cycle where valid && ready. Ready outputs are combinational from the valids, if_flush and the starvation state only; they never depend on ram_rd_data.
- Arbitration, default: LS has strict priority.
  - ls_req_ready = 1.
  - if_req_ready = !ls_req_valid && !if_flush.
- Issue timing:
  - A request accepted at cycle t drives ram_* at t+1, as a one-cycle strobe.
  - On an idle cycle, ram_rd_en and ram_wr_en are 0 and addresses/data hold their last value.
  - An LS write drives ram_wr_*; an LS read or an IF request drives ram_rd_*. Never both in one cycle.
- Tag pipeline:
  - Depth RD_LATENCY+1; each entry holds {valid, owner} (owner 0 = IF, 1 = LS).
  - An entry is pushed for every accepted read and shifts each cycle.
  - When the oldest entry is valid, response data = ram_rd_data at t+1+RD_LATENCY: owner IF drives if_rsp_valid/if_rsp_data, owner LS drives ls_rsp_valid/ls_rsp_data. The valid pulses for 1 cycle.
  - Read-response latency is therefore RD_LATENCY+1 cycles after acceptance.
  - Both responders share the RAM's single result, so at most one rsp_valid is high per cycle.
- Writes produce no response and no tag entry.
- Flush:
  - if_flush clears the valid bit of every IF-owned tag entry in the same edge.
  - No if_rsp_valid is produced for reads accepted at or before the flush cycle.
  - LS entries are unaffected.
  - if_req_ready is 0 during the flush cycle.
- Simultaneous events:
  - LS and IF both valid: LS wins and IF holds its request stable.
  - Flush in the same cycle as an IF response: that response is suppressed.
- Back-to-back: one accepted read per cycle sustained, with no bubbles.
- Data hazard: a write accepted at t and a read of the same address accepted at t+1 issue in that order. RAM write-before-read ordering is the RAM's contract.
- Reset asserted mid-operation: in-flight reads are dropped silently; requesters reissue after release.

Optional Feature:
- Macro: RAM_ARB_STARVE_GUARD_EN.
- When defined:
  - A counter increments on each cycle with if_req_valid && !if_req_ready && !if_flush.
  - The counter saturates at STARVE_LIMIT.
  - While the count equals STARVE_LIMIT: if_req_ready = !if_flush and ls_req_ready = 0.
  - The counter clears on an IF acceptance, on flush, or when if_req_valid = 0.
- When undefined: no counter is present and LS has strict priority forever.

Test Plan:
- Reset, RD_LATENCY=1: IF read of addr 0x0 accepted at t=0 -> ram_rd_en=1, ram_rd_addr=0x0 at t=1; if_rsp_valid=1 with RAM word at t=2.
- IF and LS both valid, LS read 0x100 -> ls_req_ready=1, if_req_ready=0; ram_rd_addr=0x100 next cycle; ls_rsp_valid two cycles after acceptance; IF accepted the following cycle.
- LS write 0x200 data 0xDEADBEEF, then LS read 0x200 -> ram_wr_en pulse with correct addr/data, no ls_rsp for the write; the read returns 0xDEADBEEF.
- IF reads at 0x0, 0x4, 0x8 back-to-back, if_flush the cycle after 0x8 is accepted, RD_LATENCY=2 -> responses for 0x0 only if already delivered; no if_rsp_valid for the remaining reads; if_req_ready=0 during the flush cycle.
- RAM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, ls_req_valid and if_req_valid held high -> LS accepted 4 cycles; on cycle 5 ls_req_ready=0 and IF accepted; LS accepted again on cycle 6.
- reset_n dropped for 1 cycle with 2 reads in flight -> all rsp_valid and ram strobes 0 immediately; no response appears after release.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface ram_port_arbiter_if;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_flush;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;

    logic        ls_req_valid;
    logic        ls_req_we;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_data;

    logic        ram_rd_en;
    logic [31:0] ram_rd_addr;
    logic [31:0] ram_rd_data;
    logic        ram_wr_en;
    logic [31:0] ram_wr_addr;
    logic [31:0] ram_wr_data;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
        input  ram_rd_data
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM between fetch (IF) and load/store (LS); command 1 cycle after accept, read data RD_LATENCY+1 after.
// Backpressure: LS strict priority via combinational readys; RAM_ARB_STARVE_GUARD_EN lets starved IF win.
module ram_port_arbiter #(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_port_arbiter_if.slave bus
);
    localparam int TAG_DEPTH = RD_LATENCY + 1;

    logic                 w_if_rdy;
    logic                 w_ls_rdy;
    logic                 w_if_acc;
    logic                 w_ls_acc;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_tail_if;
    logic                 w_tail_ls;

    logic                 r_rd_en;
    logic [31:0]          r_rd_addr;
    logic                 r_wr_en;
    logic [31:0]          r_wr_addr;
    logic [31:0]          r_wr_data;
    logic [TAG_DEPTH-1:0] r_tag_vld;
    logic [TAG_DEPTH-1:0] r_tag_own;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starved;

    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        w_ls_rdy = reset_n;
        w_if_rdy = reset_n && !bus.ls_req_valid && !bus.if_flush;
        if (w_starved) begin
            w_ls_rdy = 1'b0;
            w_if_rdy = reset_n && !bus.if_flush;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (!bus.if_req_valid || bus.if_flush || w_if_acc) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    logic w_unused_starve_limit;

    assign w_unused_starve_limit = (STARVE_LIMIT > 0);

    always_comb begin
        w_ls_rdy = reset_n;
        w_if_rdy = reset_n && !bus.ls_req_valid && !bus.if_flush;
    end
`endif

    assign w_if_acc = bus.if_req_valid && w_if_rdy;
    assign w_ls_acc = bus.ls_req_valid && w_ls_rdy;
    assign w_rd_acc = w_if_acc || (w_ls_acc && !bus.ls_req_we);
    assign w_wr_acc = w_ls_acc && bus.ls_req_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_rd_en <= w_rd_acc;
            r_wr_en <= w_wr_acc;
            if (w_if_acc) begin
                r_rd_addr <= bus.if_req_addr;
            end else if (w_rd_acc) begin
                r_rd_addr <= bus.ls_req_addr;
            end
            if (w_wr_acc) begin
                r_wr_addr <= bus.ls_req_addr;
                r_wr_data <= bus.ls_req_wdata;
            end
        end
    end

    // Owner bit: 1 = LS. Flush kills IF entries as they shift, so the tail is already clean next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld[0] <= w_rd_acc;
            r_tag_own[0] <= w_ls_acc;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1] && !(bus.if_flush && !r_tag_own[i-1]);
                r_tag_own[i] <= r_tag_own[i-1];
            end
        end
    end

    assign w_tail_if = r_tag_vld[TAG_DEPTH-1] && !r_tag_own[TAG_DEPTH-1] && !bus.if_flush;
    assign w_tail_ls = r_tag_vld[TAG_DEPTH-1] &&  r_tag_own[TAG_DEPTH-1];

    assign bus.if_req_ready = w_if_rdy;
    assign bus.ls_req_ready = w_ls_rdy;
    assign bus.if_rsp_valid = w_tail_if;
    assign bus.if_rsp_data  = w_tail_if ? bus.ram_rd_data : 32'h0;
    assign bus.ls_rsp_valid = w_tail_ls;
    assign bus.ls_rsp_data  = w_tail_ls ? bus.ram_rd_data : 32'h0;
    assign bus.ram_rd_en    = r_rd_en;
    assign bus.ram_rd_addr  = r_rd_addr;
    assign bus.ram_wr_en    = r_wr_en;
    assign bus.ram_wr_addr  = r_wr_addr;
    assign bus.ram_wr_data  = r_wr_data;
endmodule
